// File: rtl/mem_io_bridge.sv
// mem_io_bridge
// Splits the CPU external bus into a 128 KB synchronous RAM and a small
// memory-mapped I/O space (UART TX FIFO, UART RX, cycle counter, stop flag).
// Read data comes back on mem_din one cycle after the address.
//
// Ports
//   clk_in, rst_in     clock, asynchronous active-high reset
//   rdy_in             qualifies the current bus cycle
//   mem_a/mem_dout/mem_wr  CPU address, write byte, write strobe
//   mem_din            read byte, valid the cycle after the address
//   io_buffer_full     TX FIFO near-full throttle for the CPU
//   ram_we/ram_a/ram_wdata/ram_rdata  synchronous RAM port
//   tx_valid/tx_data/tx_ready         TX FIFO head towards the UART
//   rx_empty/rx_data/rx_pop           external RX FIFO head
//   program_finish     sticky stop flag
//   tx_overflow        sticky: a byte was dropped on a full TX FIFO
module mem_io_bridge #(
   parameter int TX_DEPTH    = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        ram_we,
   output logic [16:0] ram_a,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_empty,
   input  logic [7:0]  rx_data,
   output logic        rx_pop,
   output logic        program_finish,
   output logic        tx_overflow
);

   localparam int          PW        = $clog2(TX_DEPTH);
   localparam logic [PW:0] DEPTH_C   = (PW+1)'(TX_DEPTH);
   localparam logic [PW:0] FULL_TH_C = (PW+1)'(TX_DEPTH - FULL_MARGIN);
   localparam logic [17:0] ADDR_UART = 18'h30000;
   localparam logic [17:0] ADDR_CNT0 = 18'h30004;
   localparam logic [17:0] ADDR_CNT1 = 18'h30005;
   localparam logic [17:0] ADDR_CNT2 = 18'h30006;
   localparam logic [17:0] ADDR_CNT3 = 18'h30007;

   typedef enum logic {SEL_RAM = 1'b0, SEL_IO = 1'b1} sel_e;

   logic [17:0]   addr_s;
   logic          is_io_s, bus_wr_s, bus_rd_s;
   logic          push_req_s, push_s, pop_s, full_s;
   logic [7:0]    io_rd_val_s;

   logic [7:0]    fifo_mem_q [TX_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [31:0]   cnt_q, cnt_d, snap_q, snap_d;
   sel_e          sel_q, sel_d;
   logic [7:0]    io_rdata_q, io_rdata_d;
   logic          finish_q, finish_d, ovf_q, ovf_d;

   // Bus decode; only qualified cycles touch RAM, FIFOs or flags.
   assign addr_s    = mem_a[17:0];
   assign is_io_s   = (mem_a[17:16] == 2'b11);
   assign bus_wr_s  = rdy_in & mem_wr;
   assign bus_rd_s  = rdy_in & ~mem_wr;
   assign ram_we    = bus_wr_s & ~is_io_s;
   assign ram_a     = mem_a[16:0];
   assign ram_wdata = mem_dout;
   assign rx_pop    = bus_rd_s & (addr_s == ADDR_UART) & ~rx_empty;

   // Full is judged on the registered count, so a pop in the same cycle
   // cannot make room for a push.
   assign push_req_s = bus_wr_s & (addr_s == ADDR_UART) & (mem_dout != 8'h00);
   assign full_s     = (count_q == DEPTH_C);
   assign push_s     = push_req_s & ~full_s;
   assign tx_valid   = (count_q != '0);
   assign pop_s      = tx_valid & tx_ready;
   // Storage is not reset, so mask the head while the FIFO is empty.
   assign tx_data        = tx_valid ? fifo_mem_q[rd_ptr_q] : 8'h00;
   assign io_buffer_full = (count_q >= FULL_TH_C);

   assign mem_din        = (sel_q == SEL_RAM) ? ram_rdata : io_rdata_q;
   assign program_finish = finish_q;
   assign tx_overflow    = ovf_q;

   // I/O read data for the current address; byte 0 comes straight from the
   // live counter because that same read refreshes the snapshot.
   always_comb begin
      io_rd_val_s = 8'h00;
      case (addr_s)
         ADDR_UART: io_rd_val_s = rx_empty ? 8'h00 : rx_data;
         ADDR_CNT0: io_rd_val_s = cnt_q[7:0];
         ADDR_CNT1: io_rd_val_s = snap_q[15:8];
         ADDR_CNT2: io_rd_val_s = snap_q[23:16];
         ADDR_CNT3: io_rd_val_s = snap_q[31:24];
         default:   io_rd_val_s = 8'h00;
      endcase
   end

   // TX FIFO pointer and occupancy next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Read-return select, snapshot and sticky flags next state.
   always_comb begin
      sel_d      = sel_q;
      io_rdata_d = io_rdata_q;
      snap_d     = snap_q;
      finish_d   = finish_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q + 32'd1;
      if (bus_wr_s) begin
         sel_d      = SEL_IO;
         io_rdata_d = 8'h00;
         if (addr_s == ADDR_CNT0) begin
            finish_d = 1'b1;
         end else begin
            finish_d = finish_q;
         end
         if (push_req_s && full_s) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
      end else if (bus_rd_s) begin
         if (is_io_s) begin
            sel_d      = SEL_IO;
            io_rdata_d = io_rd_val_s;
         end else begin
            sel_d      = SEL_RAM;
            io_rdata_d = io_rdata_q;
         end
         if (addr_s == ADDR_CNT0) begin
            snap_d = cnt_q;
         end else begin
            snap_d = snap_q;
         end
      end else begin
         sel_d      = sel_q;
         io_rdata_d = io_rdata_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         cnt_q      <= 32'd0;
         snap_q     <= 32'd0;
         sel_q      <= SEL_IO;
         io_rdata_q <= 8'h00;
         finish_q   <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         cnt_q      <= cnt_d;
         snap_q     <= snap_d;
         sel_q      <= sel_d;
         io_rdata_q <= io_rdata_d;
         finish_q   <= finish_d;
         ovf_q      <= ovf_d;
      end
   end

   // FIFO storage; contents are meaningless once count says empty.
   always_ff @(posedge clk_in) begin
      if (push_s) begin
         fifo_mem_q[wr_ptr_q] <= mem_dout;
      end
   end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed scenarios followed by a
// randomized phase, all checked against a transaction-level model
// (byte queue for the TX FIFO, associative array for RAM, edge counter).
module tb_mem_io_bridge;
   localparam int TX_DEPTH    = 8;
   localparam int FULL_MARGIN = 2;

   logic        clk = 1'b0;
   logic        rst_in, rdy_in, mem_wr, ram_we, tx_valid, tx_ready;
   logic        rx_empty, rx_pop, io_buffer_full, program_finish, tx_overflow;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout, mem_din, ram_wdata, ram_rdata, tx_data, rx_data;
   logic [16:0] ram_a;

   always #5 clk = ~clk;

   mem_io_bridge #(.TX_DEPTH(TX_DEPTH), .FULL_MARGIN(FULL_MARGIN)) dut (
      .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
      .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
      .io_buffer_full(io_buffer_full), .ram_we(ram_we), .ram_a(ram_a),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready), .rx_empty(rx_empty),
      .rx_data(rx_data), .rx_pop(rx_pop), .program_finish(program_finish),
      .tx_overflow(tx_overflow));

   // External synchronous RAM
   logic [7:0] ram_arr [0:131071];
   always @(posedge clk) begin
      if (ram_we) ram_arr[ram_a] <= ram_wdata;
      ram_rdata <= ram_arr[ram_a];
   end

   // Reference model state
   logic [7:0]  ram_m [int];
   logic [7:0]  txq [$];
   logic        ovf_m, fin_m, exp_din_v;
   logic [31:0] cnt_m, snap_m;
   logic [7:0]  exp_din;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      txq.delete();
      ovf_m     = 1'b0;
      fin_m     = 1'b0;
      cnt_m     = 32'd0;
      snap_m    = 32'd0;
      exp_din   = 8'h00;
      exp_din_v = 1'b1;
   endtask

   // One bus cycle: drive, check combinational and registered outputs,
   // advance the model, clock.
   task automatic bus(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d);
      logic [17:0] off;
      logic        io, full, push;
      off = a[17:0];
      io  = (a[17:16] == 2'b11);
      rdy_in = rdy; mem_wr = wr; mem_a = a; mem_dout = d;
      #1;
      chk("ram_we", 32'(ram_we), 32'(rdy & wr & ~io));
      chk("ram_a", 32'(ram_a), 32'(a[16:0]));
      chk("rx_pop", 32'(rx_pop), 32'(rdy & ~wr & (off == 18'h30000) & ~rx_empty));
      chk("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
      chk("tx_data", 32'(tx_data), 32'((txq.size() != 0) ? txq[0] : 8'h00));
      chk("io_buffer_full", 32'(io_buffer_full), 32'(txq.size() >= TX_DEPTH - FULL_MARGIN));
      chk("tx_overflow", 32'(tx_overflow), 32'(ovf_m));
      chk("program_finish", 32'(program_finish), 32'(fin_m));
      if (exp_din_v) chk("mem_din", 32'(mem_din), 32'(exp_din));
      // expected read return for next cycle
      exp_din_v = rdy;
      if (rdy && wr) exp_din = 8'h00;
      else if (rdy && !io) begin
         exp_din_v = ram_m.exists(int'(a[16:0]));
         exp_din   = exp_din_v ? ram_m[int'(a[16:0])] : 8'h00;
      end else if (rdy) begin
         case (off)
            18'h30000: exp_din = rx_empty ? 8'h00 : rx_data;
            18'h30004: exp_din = cnt_m[7:0];
            18'h30005: exp_din = snap_m[15:8];
            18'h30006: exp_din = snap_m[23:16];
            18'h30007: exp_din = snap_m[31:24];
            default:   exp_din = 8'h00;
         endcase
      end
      if (rdy && !wr && off == 18'h30004) snap_m = cnt_m;
      if (rdy && wr && off == 18'h30004) fin_m = 1'b1;
      if (rdy && wr && !io) ram_m[int'(a[16:0])] = d;
      full = (txq.size() == TX_DEPTH);
      push = rdy && wr && off == 18'h30000 && d != 8'h00;
      if (push && full) ovf_m = 1'b1;
      if (txq.size() != 0 && tx_ready) void'(txq.pop_front());
      if (push && !full) txq.push_back(d);
      @(posedge clk);
      cnt_m = cnt_m + 32'd1;
      #2;
   endtask

   task automatic idle();
      bus(1'b0, 1'b0, 32'h0, 8'h00);
   endtask

   initial begin
      logic [31:0] a;
      logic [7:0]  d;
      rst_in = 1'b1; rdy_in = 1'b0; mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h00;
      tx_ready = 1'b0; rx_empty = 1'b1; rx_data = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      chk("rst_mem_din", 32'(mem_din), 32'h00);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h00);
      chk("rst_full", 32'(io_buffer_full), 32'h0);
      chk("rst_finish", 32'(program_finish), 32'h0);
      chk("rst_ovf", 32'(tx_overflow), 32'h0);
      rst_in = 1'b0;

      // RAM write then read
      bus(1'b1, 1'b1, 32'h0000_0100, 8'hAB);
      bus(1'b1, 1'b0, 32'h0000_0100, 8'h00);
      chk("ram_readback", 32'(mem_din), 32'h0000_00AB);

      // UART pushes with a zero byte ignored, then drain
      bus(1'b1, 1'b1, 32'h0003_0000, 8'h41);
      bus(1'b1, 1'b1, 32'h0003_0000, 8'h00);
      bus(1'b1, 1'b1, 32'h0003_0000, 8'h42);
      chk("tx_head_41", 32'(tx_data), 32'h41);
      chk("tx_count_2", 32'(txq.size()), 32'd2);
      tx_ready = 1'b1;
      idle();
      chk("tx_head_42", 32'(tx_data), 32'h42);
      idle();
      idle();
      chk("tx_drained", 32'(tx_valid), 32'h0);

      // Near-full threshold and overflow
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus(1'b1, 1'b1, 32'h0003_0000, 8'(8'h10 + i));
         if (i == 4) chk("full_after5", 32'(io_buffer_full), 32'h0);
         if (i == 5) chk("full_after6", 32'(io_buffer_full), 32'h1);
         if (i == 7) chk("ovf_after8", 32'(tx_overflow), 32'h0);
      end
      chk("ovf_after9", 32'(tx_overflow), 32'h1);
      tx_ready = 1'b1;
      repeat (10) idle();

      // RX read with data and with empty FIFO
      rx_empty = 1'b0; rx_data = 8'h5A;
      bus(1'b1, 1'b0, 32'h0003_0000, 8'h00);
      chk("rx_data_5a", 32'(mem_din), 32'h5A);
      rx_empty = 1'b1;
      bus(1'b1, 1'b0, 32'h0003_0000, 8'h00);
      chk("rx_empty_00", 32'(mem_din), 32'h00);

      // Counter snapshot at 300 cycles
      while (cnt_m < 32'd300) idle();
      bus(1'b1, 1'b0, 32'h0003_0004, 8'h00);
      chk("cnt_b0", 32'(mem_din), 32'h2C);
      bus(1'b1, 1'b0, 32'h0003_0005, 8'h00);
      chk("cnt_b1", 32'(mem_din), 32'h01);
      bus(1'b1, 1'b0, 32'h0003_0006, 8'h00);
      chk("cnt_b2", 32'(mem_din), 32'h00);
      bus(1'b1, 1'b0, 32'h0003_0007, 8'h00);
      chk("cnt_b3", 32'(mem_din), 32'h00);

      // Stop flag, then asynchronous reset mid-operation
      tx_ready = 1'b0;
      bus(1'b1, 1'b1, 32'h0000_0200, 8'h77);
      bus(1'b1, 1'b1, 32'h0003_0000, 8'h99);
      bus(1'b1, 1'b1, 32'h0003_0004, 8'h00);
      chk("finish_set", 32'(program_finish), 32'h1);
      idle();
      bus(1'b1, 1'b0, 32'h0000_0200, 8'h00);
      chk("finish_sticky", 32'(program_finish), 32'h1);
      chk("pre_rst_din", 32'(mem_din), 32'h77);
      rst_in = 1'b1;
      #1;
      chk("arst_finish", 32'(program_finish), 32'h0);
      chk("arst_tx_valid", 32'(tx_valid), 32'h0);
      chk("arst_mem_din", 32'(mem_din), 32'h00);
      chk("arst_full", 32'(io_buffer_full), 32'h0);
      @(posedge clk);
      #2;
      rst_in = 1'b0;
      model_reset();

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         a = $urandom;
         case ($urandom_range(0, 5))
            0: a[17:0] = 18'h00100 + 18'($urandom_range(0, 15));
            1: a[17:0] = 18'h10100 + 18'($urandom_range(0, 15));
            2, 3: a[17:0] = 18'h30000;
            4: a[17:0] = 18'h30004 + 18'($urandom_range(0, 3));
            default: a[17:0] = 18'h30008 + 18'($urandom_range(0, 255));
         endcase
         d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         tx_ready = ($urandom_range(0, 2) == 0);
         rx_empty = ($urandom_range(0, 1) == 0);
         rx_data  = 8'($urandom);
         bus(($urandom_range(0, 4) != 0), ($urandom_range(0, 1) == 1), a, d);
      end
      tx_ready = 1'b0;
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
